// File: rtl/round_pkg.sv
// Shared types and widths for the round timer slice.
package round_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} round_state_t;

    localparam int BCD_W = 4;
    localparam int BIN_W = 7;

endpackage

// File: rtl/bin2bcd2.sv
// Registered binary (0..99) to two-digit BCD converter, one cycle of latency.
module bin2bcd2
    import round_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    logic [BCD_W-1:0] tens_d;
    logic [BCD_W-1:0] ones_d;

    // Divide-by-10 table: the last threshold not exceeding bin sets the tens digit.
    always_comb begin
        tens_d = '0;
        ones_d = BCD_W'(bin);
        for (int unsigned i = 1; i < 10; i++) begin
            if (bin >= BIN_W'(10 * i)) begin
                tens_d = BCD_W'(i);
                ones_d = BCD_W'(bin - BIN_W'(10 * i));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= '0;
            ones <= '0;
        end else begin
            tens <= tens_d;
            ones <= ones_d;
        end
    end

endmodule

// File: rtl/round_tick_ctrl.sv
// Round countdown controller driving the tick generator enable.
// Optional blinking low-time warning output is enabled by defining ROUND_WARN_EN.
module round_tick_ctrl
    import round_pkg::*;
#(
    parameter  int ROUND_TICKS = 30,
    parameter  int WARN_TICKS  = 5,
    localparam int CNT_W       = $clog2(ROUND_TICKS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             tick,
    output logic             timer_en,
    output logic [CNT_W-1:0] remaining,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_ones,
    output logic             running,
`ifdef ROUND_WARN_EN
    output logic             warn,
`endif
    output logic             expired
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(ROUND_TICKS);
    localparam logic [CNT_W-1:0] WARN_CNT = CNT_W'(WARN_TICKS);

    if (ROUND_TICKS < 1 || ROUND_TICKS > 99 || WARN_TICKS >= ROUND_TICKS) begin : g_bad_params
        $error("round_tick_ctrl: ROUND_TICKS must be 1..99 and WARN_TICKS below it");
    end

    round_state_t     state;
    logic [CNT_W-1:0] next_rem;

    always_comb begin
        next_rem = remaining;
        if (tick && remaining != '0)
            next_rem = remaining - ONE;
    end

    // Start has priority in every state, so it is handled ahead of the state case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            timer_en  <= 1'b0;
            running   <= 1'b0;
            expired   <= 1'b0;
`ifdef ROUND_WARN_EN
            warn      <= 1'b0;
`endif
        end else begin
            expired <= 1'b0;
            if (start) begin
                state     <= RUN;
                remaining <= RELOAD;
                timer_en  <= 1'b1;
                running   <= 1'b1;
`ifdef ROUND_WARN_EN
                warn      <= 1'b0;
`endif
            end else begin
                unique case (state)
                    IDLE, DONE: ;
                    RUN: begin
                        remaining <= next_rem;
                        if (tick && remaining == ONE) begin
                            state    <= DONE;
                            timer_en <= 1'b0;
                            running  <= 1'b0;
                            expired  <= 1'b1;
`ifdef ROUND_WARN_EN
                            warn     <= 1'b0;
`endif
                        end else if (pause) begin
                            state    <= PAUSE;
                            timer_en <= 1'b0;
                            running  <= 1'b0;
`ifdef ROUND_WARN_EN
                            warn     <= (next_rem != '0) && (next_rem <= WARN_CNT);
`endif
                        end
`ifdef ROUND_WARN_EN
                        else if (tick && remaining != '0) begin
                            // First tick into the window turns warn on, later ones blink it.
                            if (next_rem <= WARN_CNT)
                                warn <= (remaining <= WARN_CNT) ? ~warn : 1'b1;
                            else
                                warn <= 1'b0;
                        end
`endif
                    end
                    PAUSE: begin
                        if (pause) begin
                            state    <= RUN;
                            timer_en <= 1'b1;
                            running  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    bin2bcd2 u_bcd (
        .clk  (clk),
        .rst  (rst),
        .bin  (BIN_W'(remaining)),
        .tens (bcd_tens),
        .ones (bcd_ones)
    );

endmodule
